// File: rtl/matmul_stream_sequencer.sv
// Streaming front end for a 2x2 unsigned matrix multiply: loads eight elements
// serially, computes C = A x B with one shared multiplier over 8 cycles, returns packed C.
module matmul_stream_sequencer #(
   parameter int ELEM_W  = 2,
   parameter int MAX_VAL = 2,
   parameter int ACC_W   = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 abort,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [ELEM_W-1:0]    in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*ACC_W-1:0]   out_data,
   output logic                 out_err,
   output logic                 busy
);

   // Handshakes: a beat moves on a rising edge where valid & ready are both high;
   // out_valid holds with stable data until out_ready; abort cancels any beat in its cycle.

   localparam int MW = ACC_W + 2 * ELEM_W;
   localparam logic [ELEM_W-1:0] MAX_E = ELEM_W'(MAX_VAL);

   typedef enum logic [1:0] {
      ST_LOAD    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_OUT     = 2'd2
   } state_t;

   state_t            state, next_state;
   logic [2:0]        cnt;
   logic [2:0]        step;
   logic              err;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  c [4];
   logic [ELEM_W-1:0] elem [8];

   logic              in_xfer;
   logic              bad_elem;
   logic [ELEM_W-1:0] a_sel, b_sel;
   logic [MW-1:0]     mul_wide;
   logic [ACC_W-1:0]  prod;

   assign in_xfer  = in_valid & in_ready;
   assign bad_elem = in_data > MAX_E;

   // Element map: a11,a12,a21,a22,b11,b12,b21,b22 -> 0..7. R = s[2], C = s[1], k = s[0].
   assign a_sel    = elem[{1'b0, step[2], step[0]}];
   assign b_sel    = elem[{1'b1, step[0], step[1]}];
   assign mul_wide = MW'(a_sel) * MW'(b_sel);
   assign prod     = mul_wide[ACC_W-1:0];
   assign out_data = {c[3], c[2], c[1], c[0]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_LOAD;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      case (state)
         ST_LOAD: begin
            in_ready = 1'b1;
            busy     = (cnt != 3'd0);
            if (in_valid && cnt == 3'd7)
               next_state = (err || bad_elem) ? ST_OUT : ST_COMPUTE;
         end
         ST_COMPUTE: begin
            busy = 1'b1;
            if (step == 3'd7) next_state = ST_OUT;
         end
         ST_OUT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) next_state = ST_LOAD;
         end
         default: next_state = ST_LOAD;
      endcase
      if (abort) next_state = ST_LOAD;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= 3'd0;
         step    <= 3'd0;
         err     <= 1'b0;
         acc     <= '0;
         out_err <= 1'b0;
         for (int i = 0; i < 4; i++) c[i] <= '0;
         for (int i = 0; i < 8; i++) elem[i] <= '0;
      end else if (abort) begin
         cnt     <= 3'd0;
         step    <= 3'd0;
         err     <= 1'b0;
         out_err <= 1'b0;
      end else begin
         case (state)
            ST_LOAD: begin
               if (in_xfer) begin
                  elem[cnt] <= in_data;
                  cnt       <= cnt + 3'd1;
                  if (bad_elem) err <= 1'b1;
                  if (cnt == 3'd7) begin
                     step <= 3'd0;
                     // Error path skips compute: result is zeroed and flagged.
                     if (err || bad_elem) begin
                        out_err <= 1'b1;
                        for (int i = 0; i < 4; i++) c[i] <= '0;
                     end else begin
                        out_err <= 1'b0;
                     end
                  end
               end
            end
            ST_COMPUTE: begin
               step <= step + 3'd1;
               if (!step[0]) acc <= prod;
               else          c[step[2:1]] <= acc + prod;
            end
            ST_OUT: begin
               if (out_ready) begin
                  cnt     <= 3'd0;
                  err     <= 1'b0;
                  out_err <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
